// File: rtl/pixel_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pixel_issue_scheduler
// Purpose  : Sweeps raster coordinates and issues one pixel per cycle into a
//            fixed-latency, non-stallable RGB datapath. Each pixel's x/y is
//            re-attached to its in-order returning colour. A new pixel is
//            issued only when a result-FIFO slot is reserved for it.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_issue_scheduler #(
   parameter int H_RES        = 1280,
   parameter int V_RES        = 720,
   parameter int MAX_INFLIGHT = 64
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic        issue_en_in,
   output logic        busy_out,
   output logic        frame_done_out,
   output logic [10:0] pix_x_out,
   output logic [9:0]  pix_y_out,
   output logic        pix_valid_out,
   input  logic        res_valid_in,
   input  logic [3:0]  res_r_in,
   input  logic [3:0]  res_g_in,
   input  logic [3:0]  res_b_in,
   output logic [10:0] x_out,
   output logic [9:0]  y_out,
   output logic [3:0]  r_out,
   output logic [3:0]  g_out,
   output logic [3:0]  b_out,
   output logic        rgb_valid_out,
   input  logic        rgb_ready_in,
   output logic        err_out
);

   localparam int c_AW = $clog2(MAX_INFLIGHT);
   localparam int c_CW = c_AW + 1;
   localparam int c_TW = 21;              // {x, y}
   localparam int c_RW = 33;              // {x, y, r, g, b}
   localparam logic [10:0]   c_X_LAST  = 11'(H_RES - 1);
   localparam logic [9:0]    c_Y_LAST  = 10'(V_RES - 1);
   localparam logic [c_CW:0] c_CREDITS = (c_CW + 1)'(MAX_INFLIGHT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          r_state;
   logic [10:0]     r_x;
   logic [9:0]      r_y;
   logic            r_pix_valid;
   logic [10:0]     r_pix_x;
   logic [9:0]      r_pix_y;
   logic            r_busy;
   logic            r_done;
   logic            r_err;

   logic [c_TW-1:0] r_tag_mem [MAX_INFLIGHT];
   logic [c_AW-1:0] r_tag_wr;
   logic [c_AW-1:0] r_tag_rd;
   logic [c_CW-1:0] r_tag_count;

   logic [c_RW-1:0] r_res_mem [MAX_INFLIGHT];
   logic [c_AW-1:0] r_res_wr;
   logic [c_AW-1:0] r_res_rd;
   logic [c_CW-1:0] r_res_count;

   logic [c_CW:0]   w_inflight;
   logic            w_issue;
   logic            w_tag_pop;
   logic            w_rgb_valid;
   logic            w_res_pop;
   logic [c_TW-1:0] w_tag_head;
   logic [c_RW-1:0] w_res_head;

   // A pixel may issue only if its eventual result is guaranteed a FIFO slot:
   // tags still in the datapath plus results already queued hold all credits.
   assign w_inflight  = {1'b0, r_tag_count} + {1'b0, r_res_count};
   assign w_issue     = (r_state == S_ISSUE) && issue_en_in && (w_inflight < c_CREDITS);
   // A result with no outstanding tag is an error and is dropped.
   assign w_tag_pop   = res_valid_in && (r_tag_count != '0);
   assign w_rgb_valid = (r_res_count != '0);
   assign w_res_pop   = w_rgb_valid && rgb_ready_in;
   assign w_tag_head  = r_tag_mem[r_tag_rd];
   assign w_res_head  = r_res_mem[r_res_rd];

   assign busy_out       = r_busy;
   assign frame_done_out = r_done;
   assign pix_x_out      = r_pix_x;
   assign pix_y_out      = r_pix_y;
   assign pix_valid_out  = r_pix_valid;
   assign rgb_valid_out  = w_rgb_valid;
   assign err_out        = r_err;
   // Head data is masked while empty so the unreset storage never leaks out.
   assign {x_out, y_out, r_out, g_out, b_out} = w_rgb_valid ? w_res_head : '0;

   // Frame state machine, raster sweep and registered issue/status outputs
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_y         <= '0;
         r_pix_valid <= 1'b0;
         r_pix_x     <= '0;
         r_pix_y     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_pix_valid <= w_issue;
         r_done      <= 1'b0;
         if (w_issue) begin
            r_pix_x <= r_x;
            r_pix_y <= r_y;
         end
         case (r_state)
            S_IDLE: begin
               if (start_in) begin
                  r_state <= S_ISSUE;
                  r_busy  <= 1'b1;
                  r_x     <= '0;
                  r_y     <= '0;
               end
            end
            S_ISSUE: begin
               if (w_issue) begin
                  if (r_x == c_X_LAST) begin
                     r_x <= '0;
                     if (r_y == c_Y_LAST) begin
                        r_y     <= '0;
                        r_state <= S_DRAIN;
                     end else begin
                        r_y <= r_y + 10'd1;
                     end
                  end else begin
                     r_x <= r_x + 11'd1;
                  end
               end
            end
            S_DRAIN: begin
               if ((r_tag_count == '0) && (r_res_count == '0)) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Tag/result FIFO pointers, occupancy counts and the sticky error flag
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         r_tag_wr    <= '0;
         r_tag_rd    <= '0;
         r_tag_count <= '0;
         r_res_wr    <= '0;
         r_res_rd    <= '0;
         r_res_count <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_issue)   r_tag_wr <= r_tag_wr + c_AW'(1);
         if (w_tag_pop) r_tag_rd <= r_tag_rd + c_AW'(1);
         if (w_tag_pop) r_res_wr <= r_res_wr + c_AW'(1);
         if (w_res_pop) r_res_rd <= r_res_rd + c_AW'(1);

         case ({w_issue, w_tag_pop})
            2'b10:   r_tag_count <= r_tag_count + c_CW'(1);
            2'b01:   r_tag_count <= r_tag_count - c_CW'(1);
            default: r_tag_count <= r_tag_count;
         endcase

         case ({w_tag_pop, w_res_pop})
            2'b10:   r_res_count <= r_res_count + c_CW'(1);
            2'b01:   r_res_count <= r_res_count - c_CW'(1);
            default: r_res_count <= r_res_count;
         endcase

         if (res_valid_in && (r_tag_count == '0)) r_err <= 1'b1;
      end
   end

   // FIFO storage; contents are don't-care until the matching count covers them
   always_ff @(posedge clk_in) begin
      if (w_issue)   r_tag_mem[r_tag_wr] <= {r_x, r_y};
      if (w_tag_pop) r_res_mem[r_res_wr] <= {w_tag_head, res_r_in, res_g_in, res_b_in};
   end

endmodule
`default_nettype wire

// File: tb/tb_pixel_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_issue_scheduler
// Purpose  : Directed self-checking bench. Instance A (4x2, 8 credits) covers
//            the frame sweep, gating, simultaneous push/pop, error and reset
//            behaviour; instance B (4x2, 4 credits) covers credit stalls.
//            Model datapath colour: r = x+4y, g = r^5, b = r+3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_issue_scheduler;

   logic clk_in = 1'b0;
   logic rst_in;
   always #5 clk_in = ~clk_in;

   int cyc = 0;
   always @(posedge clk_in) cyc <= cyc + 1;

   int n_chk  = 0;
   int n_pass = 0;

   // ---------------- instance A ----------------
   logic        start_a, en_a, ready_a, force_res;
   logic        busy_a, done_a, pixv_a, rgbv_a, err_a, resv_a;
   logic [10:0] px_a, x_a;
   logic [9:0]  py_a, y_a;
   logic [3:0]  rr_a, rg_a, rb_a, r_a, g_a, b_a;
   logic [2:0]  lat_a = 3'd5;
   logic        pv_a [8];
   logic [3:0]  pc_a [8];

   pixel_issue_scheduler #(.H_RES(4), .V_RES(2), .MAX_INFLIGHT(8)) dut_a (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_a), .issue_en_in(en_a),
      .busy_out(busy_a), .frame_done_out(done_a), .pix_x_out(px_a), .pix_y_out(py_a),
      .pix_valid_out(pixv_a), .res_valid_in(resv_a), .res_r_in(rr_a), .res_g_in(rg_a),
      .res_b_in(rb_a), .x_out(x_a), .y_out(y_a), .r_out(r_a), .g_out(g_a), .b_out(b_a),
      .rgb_valid_out(rgbv_a), .rgb_ready_in(ready_a), .err_out(err_a));

   // Fixed-latency datapath model for A, cleared by the shared reset
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         for (int i = 0; i < 8; i++) begin pv_a[i] <= 1'b0; pc_a[i] <= 4'd0; end
      end else begin
         pv_a[0] <= pixv_a;
         pc_a[0] <= px_a[3:0] + {py_a[1:0], 2'b00};
         for (int i = 1; i < 8; i++) begin pv_a[i] <= pv_a[i-1]; pc_a[i] <= pc_a[i-1]; end
      end
   end
   assign resv_a = pv_a[lat_a - 3'd1] | force_res;
   assign rr_a   = pc_a[lat_a - 3'd1];
   assign rg_a   = pc_a[lat_a - 3'd1] ^ 4'h5;
   assign rb_a   = pc_a[lat_a - 3'd1] + 4'd3;

   // ---------------- instance B ----------------
   logic        start_b, en_b, ready_b;
   logic        busy_b, done_b, pixv_b, rgbv_b, err_b, resv_b;
   logic [10:0] px_b, x_b;
   logic [9:0]  py_b, y_b;
   logic [3:0]  rr_b, rg_b, rb_b, r_b, g_b, b_b;
   logic        pv_b [2];
   logic [3:0]  pc_b [2];

   pixel_issue_scheduler #(.H_RES(4), .V_RES(2), .MAX_INFLIGHT(4)) dut_b (
      .clk_in(clk_in), .rst_in(rst_in), .start_in(start_b), .issue_en_in(en_b),
      .busy_out(busy_b), .frame_done_out(done_b), .pix_x_out(px_b), .pix_y_out(py_b),
      .pix_valid_out(pixv_b), .res_valid_in(resv_b), .res_r_in(rr_b), .res_g_in(rg_b),
      .res_b_in(rb_b), .x_out(x_b), .y_out(y_b), .r_out(r_b), .g_out(g_b), .b_out(b_b),
      .rgb_valid_out(rgbv_b), .rgb_ready_in(ready_b), .err_out(err_b));

   // Two-stage datapath model for B
   always @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         pv_b[0] <= 1'b0; pv_b[1] <= 1'b0; pc_b[0] <= 4'd0; pc_b[1] <= 4'd0;
      end else begin
         pv_b[0] <= pixv_b;
         pc_b[0] <= px_b[3:0] + {py_b[1:0], 2'b00};
         pv_b[1] <= pv_b[0];
         pc_b[1] <= pc_b[0];
      end
   end
   assign resv_b = pv_b[1];
   assign rr_b   = pc_b[1];
   assign rg_b   = pc_b[1] ^ 4'h5;
   assign rb_b   = pc_b[1] + 4'd3;

   // ---------------- monitors ----------------
   logic [20:0] iss_a[$], iss_b[$];
   int          iss_cyc_a[$];
   logic [32:0] out_a[$], out_b[$];
   int          done_cnt_a, done_cnt_b, max_out_a, max_out_b;

   initial forever begin
      @(negedge clk_in);
      if (pixv_a) begin iss_a.push_back({px_a, py_a}); iss_cyc_a.push_back(cyc); end
      if (iss_a.size() - out_a.size() > max_out_a) max_out_a = iss_a.size() - out_a.size();
      if (rgbv_a && ready_a) out_a.push_back({x_a, y_a, r_a, g_a, b_a});
      if (done_a) done_cnt_a++;
      if (pixv_b) iss_b.push_back({px_b, py_b});
      if (iss_b.size() - out_b.size() > max_out_b) max_out_b = iss_b.size() - out_b.size();
      if (rgbv_b && ready_b) out_b.push_back({x_b, y_b, r_b, g_b, b_b});
      if (done_b) done_cnt_b++;
   end

   // ---------------- helpers ----------------
   function automatic logic [20:0] exp_coord(input int i);
      logic [10:0] ex;
      logic [9:0]  ey;
      ex = 11'(i % 4);
      ey = 10'(i / 4);
      return {ex, ey};
   endfunction

   function automatic logic [32:0] exp_res(input int i);
      logic [3:0] c;
      c = 4'(i);
      return {exp_coord(i), c, c ^ 4'h5, c + 4'd3};
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   task automatic clear_logs();
      iss_a.delete(); iss_cyc_a.delete(); out_a.delete();
      iss_b.delete(); out_b.delete();
      done_cnt_a = 0; done_cnt_b = 0; max_out_a = 0; max_out_b = 0;
   endtask

   task automatic wait_done_a(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge clk_in);
         if (done_a) ok = 1'b1;
      end
      repeat (2) @(negedge clk_in);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_in = 1'b1;
      start_a = 0; en_a = 0; ready_a = 0; force_res = 0;
      start_b = 0; en_b = 0; ready_b = 0;
      repeat (3) @(negedge clk_in);
      n_chk++;
      if ({busy_a, done_a, pixv_a, px_a, py_a} !== '0)
         $display("FAIL reset_issue_a: got %b want 0", {busy_a, done_a, pixv_a, px_a, py_a});
      else n_pass++;
      n_chk++;
      if ({rgbv_a, x_a, y_a, r_a, g_a, b_a, err_a} !== '0)
         $display("FAIL reset_result_a: got %h want 0", {rgbv_a, x_a, y_a, r_a, g_a, b_a, err_a});
      else n_pass++;
      n_chk++;
      if ({busy_b, done_b, pixv_b, rgbv_b, err_b, x_b, y_b, r_b, g_b, b_b} !== '0)
         $display("FAIL reset_b: got %h want 0", {busy_b, done_b, pixv_b, rgbv_b, err_b, x_b, y_b, r_b, g_b, b_b});
      else n_pass++;
      step();
      rst_in = 1'b0;
      step();
   endtask

   task automatic test_full_frame();
      bit ok;
      bit bad;
      int c0;
      lat_a = 3'd5; ready_a = 1; en_a = 1;
      clear_logs();
      step(); start_a = 1; c0 = cyc;
      step(); start_a = 0;
      n_chk++;
      if (busy_a !== 1'b1) $display("FAIL ff_busy_high: got %b want 1", busy_a); else n_pass++;
      wait_done_a(200, ok);
      n_chk++;
      if (ok !== 1'b1) $display("FAIL ff_done_seen: got %b want 1", ok); else n_pass++;
      n_chk++;
      if (iss_a.size() !== 8) $display("FAIL ff_issue_count: got %0d want 8", iss_a.size()); else n_pass++;
      n_chk++;
      if (iss_cyc_a.size() == 0 || iss_cyc_a[0] !== c0 + 2)
         $display("FAIL ff_first_issue_cycle: got %0d want %0d", (iss_cyc_a.size() > 0) ? iss_cyc_a[0] : -1, c0 + 2);
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (i >= iss_a.size() || iss_a[i] !== exp_coord(i))
            $display("FAIL ff_issue_coord[%0d]: got %h want %h", i, (i < iss_a.size()) ? iss_a[i] : 21'h0, exp_coord(i));
         else n_pass++;
      end
      bad = 0;
      for (int i = 1; i < iss_cyc_a.size(); i++) if (iss_cyc_a[i] != iss_cyc_a[0] + i) bad = 1;
      n_chk++;
      if (bad !== 1'b0) $display("FAIL ff_consecutive: got gap=%b want 0", bad); else n_pass++;
      n_chk++;
      if (out_a.size() !== 8) $display("FAIL ff_out_count: got %0d want 8", out_a.size()); else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_chk++;
         if (i >= out_a.size() || out_a[i] !== exp_res(i))
            $display("FAIL ff_out[%0d]: got %h want %h", i, (i < out_a.size()) ? out_a[i] : 33'h0, exp_res(i));
         else n_pass++;
      end
      n_chk++;
      if (done_cnt_a !== 1) $display("FAIL ff_done_pulses: got %0d want 1", done_cnt_a); else n_pass++;
      n_chk++;
      if (busy_a !== 1'b0) $display("FAIL ff_busy_after: got %b want 0", busy_a); else n_pass++;
   endtask

   task automatic test_credit_stall();
      bit ok;
      bit bad;
      ready_b = 0; en_b = 1;
      clear_logs();
      step(); start_b = 1;
      step(); start_b = 0;
      repeat (20) step();
      n_chk++;
      if (iss_b.size() !== 4) $display("FAIL cs_stall_issues: got %0d want 4", iss_b.size()); else n_pass++;
      @(negedge clk_in);
      n_chk++;
      if (pixv_b !== 1'b0) $display("FAIL cs_pix_idle: got %b want 0", pixv_b); else n_pass++;
      n_chk++;
      if ({rgbv_b, x_b, y_b, r_b, g_b, b_b} !== {1'b1, exp_res(0)})
         $display("FAIL cs_head_hold: got %h want %h", {rgbv_b, x_b, y_b, r_b, g_b, b_b}, {1'b1, exp_res(0)});
      else n_pass++;
      step(); ready_b = 1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin @(negedge clk_in); if (done_b) ok = 1; end
      repeat (2) @(negedge clk_in);
      n_chk++;
      if (ok !== 1'b1) $display("FAIL cs_done_seen: got %b want 1", ok); else n_pass++;
      bad = (iss_b.size() != 8) || (out_b.size() != 8);
      for (int i = 0; i < 8; i++) begin
         if (i < iss_b.size() && iss_b[i] !== exp_coord(i)) bad = 1;
         if (i < out_b.size() && out_b[i] !== exp_res(i)) bad = 1;
      end
      n_chk++;
      if (bad !== 1'b0) $display("FAIL cs_order: got bad=%b issues=%0d outs=%0d want 8/8 in order", bad, iss_b.size(), out_b.size());
      else n_pass++;
      n_chk++;
      if (max_out_b !== 4) $display("FAIL cs_max_inflight: got %0d want 4", max_out_b); else n_pass++;
   endtask

   task automatic test_upstream_gating();
      bit ok;
      bit bad;
      bit pat  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      bit expv [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [20:0] expc [6];
      expc[0] = '0; expc[1] = exp_coord(0); expc[2] = '0;
      expc[3] = '0; expc[4] = exp_coord(1); expc[5] = '0;
      lat_a = 3'd1; ready_a = 1; en_a = 0;
      clear_logs();
      step(); start_a = 1;
      step(); start_a = 0;
      for (int k = 0; k < 6; k++) begin
         en_a = pat[k];
         @(negedge clk_in);
         n_chk++;
         if (pixv_a !== expv[k] || (expv[k] && {px_a, py_a} !== expc[k]))
            $display("FAIL gate_step[%0d]: got v=%b xy=%h want v=%b xy=%h", k, pixv_a, {px_a, py_a}, expv[k], expc[k]);
         else n_pass++;
         step();
      end
      // start while a frame is running must not restart the raster
      en_a = 0; start_a = 1;
      step(); start_a = 0; en_a = 1;
      step(); en_a = 0;
      @(negedge clk_in);
      n_chk++;
      if ({pixv_a, px_a, py_a} !== {1'b1, exp_coord(2)})
         $display("FAIL start_ignored: got %h want %h", {pixv_a, px_a, py_a}, {1'b1, exp_coord(2)});
      else n_pass++;
      step(); en_a = 1;
      wait_done_a(200, ok);
      bad = !ok || (iss_a.size() != 8) || (out_a.size() != 8) || (done_cnt_a != 1);
      for (int i = 0; i < 8; i++) begin
         if (i < iss_a.size() && iss_a[i] !== exp_coord(i)) bad = 1;
         if (i < out_a.size() && out_a[i] !== exp_res(i)) bad = 1;
      end
      n_chk++;
      if (bad !== 1'b0) $display("FAIL gate_frame: got bad=%b issues=%0d outs=%0d want 8/8 in order", bad, iss_a.size(), out_a.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bit ok;
      bit bad;
      lat_a = 3'd1; ready_a = 0; en_a = 1;
      clear_logs();
      step(); start_a = 1;
      step(); start_a = 0;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         ready_a = ~ready_a;
         @(negedge clk_in);
         if (done_a) ok = 1;
         step();
      end
      ready_a = 1;
      repeat (2) @(negedge clk_in);
      n_chk++;
      if (ok !== 1'b1) $display("FAIL b2b_done_seen: got %b want 1", ok); else n_pass++;
      bad = (out_a.size() != 8);
      for (int i = 0; i < 8; i++) if (i < out_a.size() && out_a[i] !== exp_res(i)) bad = 1;
      n_chk++;
      if (bad !== 1'b0) $display("FAIL b2b_order: got bad=%b outs=%0d want 8 in order", bad, out_a.size()); else n_pass++;
      n_chk++;
      if (max_out_a > 8) $display("FAIL b2b_credit: got %0d want <=8", max_out_a); else n_pass++;
   endtask

   task automatic test_error_ignore();
      n_chk++;
      if (err_a !== 1'b0) $display("FAIL err_initial: got %b want 0", err_a); else n_pass++;
      step(); force_res = 1;
      step(); force_res = 0;
      @(negedge clk_in);
      n_chk++;
      if ({err_a, rgbv_a} !== 2'b10) $display("FAIL err_set: got err/valid=%b want 10", {err_a, rgbv_a}); else n_pass++;
      repeat (5) @(negedge clk_in);
      n_chk++;
      if ({err_a, rgbv_a, busy_a} !== 3'b100) $display("FAIL err_sticky: got %b want 100", {err_a, rgbv_a, busy_a}); else n_pass++;
   endtask

   task automatic test_async_reset();
      bit ok;
      bit found;
      bit bad;
      lat_a = 3'd5; ready_a = 0; en_a = 1;
      clear_logs();
      step(); start_a = 1;
      step(); start_a = 0;
      found = 0;
      for (int i = 0; i < 50 && !found; i++) begin
         @(negedge clk_in);
         if (pixv_a && {px_a, py_a} == exp_coord(6)) found = 1;
      end
      n_chk++;
      if (found !== 1'b1) $display("FAIL ar_reach_2_1: got %b want 1", found); else n_pass++;
      #2 rst_in = 1'b1;
      #1;
      n_chk++;
      if ({busy_a, done_a, pixv_a, px_a, py_a, rgbv_a, x_a, y_a, r_a, g_a, b_a, err_a} !== '0)
         $display("FAIL ar_outputs_zero: got %h want 0",
                  {busy_a, done_a, pixv_a, px_a, py_a, rgbv_a, x_a, y_a, r_a, g_a, b_a, err_a});
      else n_pass++;
      @(negedge clk_in);
      rst_in = 1'b0;
      clear_logs();
      ready_a = 1;
      step(); start_a = 1;
      step(); start_a = 0;
      wait_done_a(200, ok);
      n_chk++;
      if (iss_a.size() == 0 || iss_a[0] !== exp_coord(0))
         $display("FAIL ar_restart_origin: got %h want %h", (iss_a.size() > 0) ? iss_a[0] : 21'h1FFFFF, exp_coord(0));
      else n_pass++;
      bad = !ok || (iss_a.size() != 8) || (out_a.size() != 8);
      for (int i = 0; i < 8; i++) if (i < out_a.size() && out_a[i] !== exp_res(i)) bad = 1;
      n_chk++;
      if (bad !== 1'b0) $display("FAIL ar_frame: got bad=%b issues=%0d outs=%0d want 8/8", bad, iss_a.size(), out_a.size());
      else n_pass++;
      n_chk++;
      if (err_a !== 1'b0) $display("FAIL ar_err_clear: got %b want 0", err_a); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_credit_stall();
      test_upstream_gating();
      test_back_to_back();
      test_error_ignore();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
